// File: rtl/monociclo_pkg.sv
// Shared encodings, control word and built-in program for the single-cycle MIPS core.
package monociclo_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   typedef struct packed {
      logic    RegDst;
      logic    ALUSrc;
      logic    MemToReg;
      logic    RegWrite;
      logic    MemWrite;
      logic    Branch;
      logic    Jump;
      alu_op_t alu_op;
   } ctrl_t;

   // True for every opcode/funct pair the core implements.
   function automatic logic insn_known(input logic [5:0] opcode, input logic [5:0] funct);
      logic known;
      known = 1'b0;
      case (opcode)
         OP_RTYPE: known = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: known = 1'b1;
         default: known = 1'b0;
      endcase
      return known;
   endfunction

   // Main + ALU control decode; unknown encodings produce an all-inactive control word.
   function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
      ctrl_t c;
      c.RegDst   = 1'b0;
      c.ALUSrc   = 1'b0;
      c.MemToReg = 1'b0;
      c.RegWrite = 1'b0;
      c.MemWrite = 1'b0;
      c.Branch   = 1'b0;
      c.Jump     = 1'b0;
      c.alu_op   = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            c.RegDst   = 1'b1;
            c.RegWrite = 1'b1;
            case (funct)
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               default: c.RegWrite = 1'b0;
            endcase
         end
         OP_ADDI: begin
            c.ALUSrc   = 1'b1;
            c.RegWrite = 1'b1;
         end
         OP_LW: begin
            c.ALUSrc   = 1'b1;
            c.MemToReg = 1'b1;
            c.RegWrite = 1'b1;
         end
         OP_SW: begin
            c.ALUSrc   = 1'b1;
            c.MemWrite = 1'b1;
         end
         OP_BEQ: begin
            c.Branch = 1'b1;
            c.alu_op = ALU_SUB;
         end
         OP_J:    c.Jump = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Built-in test program; unused words read as 0 (an unknown R-type, i.e. a no-op).
   function automatic logic [31:0] builtin_rom(input logic [31:0] idx);
      logic [31:0] w;
      case (idx)
         32'd0:   w = 32'h2008_0005;
         32'd1:   w = 32'h2009_0003;
         32'd2:   w = 32'h0109_5020;
         32'd3:   w = 32'h0109_5822;
         32'd4:   w = 32'h0109_6024;
         32'd5:   w = 32'h0109_6825;
         32'd6:   w = 32'h0128_702A;
         32'd7:   w = 32'hAC0A_0000;
         32'd8:   w = 32'h8C0F_0000;
         32'd9:   w = 32'h11EA_0001;
         32'd10:  w = 32'h2008_00FF;
         32'd11:  w = 32'h0800_0000;
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/monociclo_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module monociclo_regfile
   import monociclo_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1_i,
   input  logic [4:0]      raddr2_i,
   output logic [XLEN-1:0] rdata1_c_o,
   output logic [XLEN-1:0] rdata2_c_o,
   input  logic            we_i,
   input  logic [4:0]      waddr_i,
   input  logic [XLEN-1:0] wdata_i
);

   localparam int unsigned NREGS = 32;

   logic [XLEN-1:0] regs_q [NREGS];

   // Synchronous clear on reset; writes to $0 are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Reads return the pre-edge value, so a same-cycle write is not forwarded.
   always_comb begin
      rdata1_c_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
      rdata2_c_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
   end

endmodule

// File: rtl/monociclo_top.sv
// Single-cycle MIPS32 subset core: fetch, decode, execute, memory and writeback in one clock.
module monociclo_top
   import monociclo_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 64,
   // "" selects the built-in program; a named image is preloaded into the ROM macro at integration.
   parameter string       INIT_FILE  = ""
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero
);

   // Memory depths are assumed to be powers of two so the index slice gives the modulo.
   localparam int unsigned IA_W        = $clog2(IMEM_WORDS);
   localparam int unsigned DA_W        = $clog2(DMEM_WORDS);
   localparam bit          USE_BUILTIN = (INIT_FILE == "");

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] dmem_q [DMEM_WORDS];

   logic [5:0]      opcode, funct;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] imm_sext, pc_plus4, br_target;
   logic [XLEN-1:0] rs_val, rt_val, alu_b, alu_raw, wb_data, mem_rdata;
   logic [4:0]      wb_addr;
   logic            known;
   ctrl_t           ctrl;

   // Fetch and field extraction.
   always_comb begin
      instruction = USE_BUILTIN ? builtin_rom(32'(pc_q[IA_W+1:2])) : '0;
      opcode      = instruction[31:26];
      rs          = instruction[25:21];
      rt          = instruction[20:16];
      rd          = instruction[15:11];
      funct       = instruction[5:0];
      imm_sext    = {{16{instruction[15]}}, instruction[15:0]};
      ctrl        = decode(opcode, funct);
      known       = insn_known(opcode, funct);
   end

   monociclo_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .raddr1_i   (rs),
      .raddr2_i   (rt),
      .rdata1_c_o (rs_val),
      .rdata2_c_o (rt_val),
      .we_i       (ctrl.RegWrite),
      .waddr_i    (wb_addr),
      .wdata_i    (wb_data)
   );

   // ALU; unknown instructions and jumps report a zero result.
   always_comb begin
      alu_b = ctrl.ALUSrc ? imm_sext : rt_val;
      case (ctrl.alu_op)
         ALU_ADD: alu_raw = rs_val + alu_b;
         ALU_SUB: alu_raw = rs_val - alu_b;
         ALU_AND: alu_raw = rs_val & alu_b;
         ALU_OR:  alu_raw = rs_val | alu_b;
         ALU_SLT: alu_raw = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_raw = '0;
      endcase
      ALUResult = (known && !ctrl.Jump) ? alu_raw : '0;
      Zero      = (ALUResult == '0);
   end

   // Data read, writeback select and next-PC selection.
   always_comb begin
      mem_rdata = dmem_q[ALUResult[DA_W+1:2]];
      wb_data   = ctrl.MemToReg ? mem_rdata : ALUResult;
      wb_addr   = ctrl.RegDst ? rd : rt;
      pc_plus4  = pc_q + 32'd4;
      br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
      pc_d      = pc_plus4;
      if (ctrl.Jump)                pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
      else if (ctrl.Branch && Zero) pc_d = br_target;
   end

   // Program counter.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   // Data RAM: contents survive reset, stores are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (!rst && ctrl.MemWrite) dmem_q[ALUResult[DA_W+1:2]] <= rt_val;
   end

endmodule

// File: tb/tb_monociclo_top.sv
// Bench for monociclo_top: ISA-level reference interpreter against the core's observable outputs.
module tb_monociclo_top;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] ALUResult;
   logic        Zero;

   int checks   = 0;
   int failures = 0;

   // Reference machine state.
   logic [31:0] prog   [64];
   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [64];
   logic [31:0] m_pc;

   monociclo_top dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .ALUResult   (ALUResult),
      .Zero        (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sext16(input logic [31:0] ins);
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic logic [31:0] m_fetch();
      return prog[(m_pc >> 2) % 64];
   endfunction

   // Architectural ALU value of an instruction given the current reference registers.
   function automatic logic [31:0] m_alu(input logic [31:0] ins);
      logic [31:0] a, b, r;
      a = m_regs[ins[25:21]];
      b = m_regs[ins[20:16]];
      r = 32'd0;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
         endcase
         6'h08, 6'h23, 6'h2B: r = a + sext16(ins);
         6'h04: r = a - b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic m_write(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) m_regs[r] = v;
   endtask

   // One clock edge of the reference machine.
   task automatic m_commit();
      logic [31:0] ins, alu, b, npc;
      ins = m_fetch();
      alu = m_alu(ins);
      b   = m_regs[ins[20:16]];
      npc = m_pc + 32'd4;
      case (ins[31:26])
         6'h00: if (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) m_write(ins[15:11], alu);
         6'h08: m_write(ins[20:16], alu);
         6'h23: m_write(ins[20:16], m_mem[(alu >> 2) % 64]);
         6'h2B: m_mem[(alu >> 2) % 64] = b;
         6'h04: if (alu == 32'd0) npc = m_pc + 32'd4 + (sext16(ins) << 2);
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic m_reset();
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
   endtask

   // Drive rst for one rising edge on both DUT and reference, return at the next falling edge.
   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      if (r) m_reset();
      else   m_commit();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      m_reset();
      @(negedge clk);
      checks++;
      if (instruction !== 32'h2008_0005) begin
         failures++;
         $display("FAIL reset_instruction: got %h expected %h", instruction, 32'h2008_0005);
      end
      checks++;
      if (ALUResult !== 32'd5) begin
         failures++;
         $display("FAIL reset_alu: got %h expected %h", ALUResult, 32'd5);
      end
      checks++;
      if (Zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_zero: got %b expected 0", Zero);
      end
      for (int r = 1; r < 32; r++) begin
         checks++;
         if (dut.u_regfile.regs_q[r] !== 32'd0) begin
            failures++;
            $display("FAIL reset_reg%0d: got %h expected 0", r, dut.u_regfile.regs_q[r]);
         end
      end
   endtask

   task automatic test_program();
      logic [31:0] exp_seq [7];
      exp_seq = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1};
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (ALUResult !== exp_seq[i] || ALUResult !== m_alu(m_fetch())) begin
            failures++;
            $display("FAIL prog_alu_w%0d: got %h expected %h", i, ALUResult, exp_seq[i]);
         end
         step(1'b0);
      end
      checks++;
      if (dut.u_regfile.regs_q[10] !== 32'd8 || dut.u_regfile.regs_q[14] !== 32'd1) begin
         failures++;
         $display("FAIL prog_regs: got r10=%h r14=%h expected r10=8 r14=1",
                  dut.u_regfile.regs_q[10], dut.u_regfile.regs_q[14]);
      end
      checks++;
      if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL sw_alu: got %h zero=%b expected 0 zero=1", ALUResult, Zero);
      end
      step(1'b0);
      checks++;
      if (dut.dmem_q[0] !== 32'd8) begin
         failures++;
         $display("FAIL sw_mem0: got %h expected 8", dut.dmem_q[0]);
      end
      step(1'b0);
      checks++;
      if (dut.u_regfile.regs_q[15] !== 32'd8) begin
         failures++;
         $display("FAIL lw_r15: got %h expected 8", dut.u_regfile.regs_q[15]);
      end
      checks++;
      if (instruction !== 32'h11EA_0001 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL beq_eval: got ins=%h alu=%h zero=%b expected ins=11ea0001 alu=0 zero=1",
                  instruction, ALUResult, Zero);
      end
      step(1'b0);
      checks++;
      if (instruction !== 32'h0800_0000 || ALUResult !== 32'd0) begin
         failures++;
         $display("FAIL beq_target: got ins=%h alu=%h expected ins=08000000 alu=0",
                  instruction, ALUResult);
      end
      step(1'b0);
      checks++;
      if (instruction !== 32'h2008_0005 || dut.u_regfile.regs_q[8] !== 32'd5) begin
         failures++;
         $display("FAIL jump_wrap: got ins=%h r8=%h expected ins=20080005 r8=5",
                  instruction, dut.u_regfile.regs_q[8]);
      end
   endtask

   // Two further passes of the loop against the reference interpreter.
   task automatic test_loop();
      for (int c = 0; c < 24; c++) begin
         checks++;
         if (instruction !== m_fetch() || ALUResult !== m_alu(m_fetch()) ||
             Zero !== (m_alu(m_fetch()) == 32'd0)) begin
            failures++;
            $display("FAIL loop_c%0d: got ins=%h alu=%h zero=%b expected ins=%h alu=%h",
                     c, instruction, ALUResult, Zero, m_fetch(), m_alu(m_fetch()));
         end
         step(1'b0);
      end
   endtask

   // Reset asserted mid-program: PC and registers clear, RAM keeps its contents.
   task automatic test_mid_reset();
      int k;
      for (int n = 0; n < 3; n++) begin
         k = (n == 0) ? 5 : int'($urandom_range(1, 11));
         for (int c = 0; c < k; c++) step(1'b0);
         step(1'b1);
         checks++;
         if (instruction !== 32'h2008_0005 || ALUResult !== 32'd5) begin
            failures++;
            $display("FAIL midrst_fetch_k%0d: got ins=%h alu=%h expected ins=20080005 alu=5",
                     k, instruction, ALUResult);
         end
         checks++;
         if (dut.u_regfile.regs_q[8] !== 32'd0 || dut.u_regfile.regs_q[10] !== 32'd0 ||
             dut.u_regfile.regs_q[13] !== 32'd0) begin
            failures++;
            $display("FAIL midrst_regs_k%0d: got r8=%h r10=%h r13=%h expected 0",
                     k, dut.u_regfile.regs_q[8], dut.u_regfile.regs_q[10], dut.u_regfile.regs_q[13]);
         end
         checks++;
         if (dut.dmem_q[0] !== 32'd8) begin
            failures++;
            $display("FAIL midrst_mem0_k%0d: got %h expected 8", k, dut.dmem_q[0]);
         end
      end
   endtask

   // Free run with random reset pulses, outputs and registers tracked by the reference.
   task automatic test_random_reset();
      logic r;
      for (int c = 0; c < 300; c++) begin
         checks++;
         if (instruction !== m_fetch() || ALUResult !== m_alu(m_fetch()) ||
             Zero !== (m_alu(m_fetch()) == 32'd0)) begin
            failures++;
            $display("FAIL rand_c%0d: got ins=%h alu=%h zero=%b expected ins=%h alu=%h",
                     c, instruction, ALUResult, Zero, m_fetch(), m_alu(m_fetch()));
         end
         for (int q = 8; q < 16; q++) begin
            checks++;
            if (dut.u_regfile.regs_q[q] !== m_regs[q]) begin
               failures++;
               $display("FAIL rand_c%0d_reg%0d: got %h expected %h",
                        c, q, dut.u_regfile.regs_q[q], m_regs[q]);
            end
         end
         r = ($urandom_range(0, 11) == 0);
         step(r);
      end
      checks++;
      if (dut.dmem_q[0] !== m_mem[0]) begin
         failures++;
         $display("FAIL rand_mem0: got %h expected %h", dut.dmem_q[0], m_mem[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         prog[i]  = 32'h0000_0000;
         m_mem[i] = 32'hxxxx_xxxx;
      end
      prog[0]  = 32'h2008_0005;
      prog[1]  = 32'h2009_0003;
      prog[2]  = 32'h0109_5020;
      prog[3]  = 32'h0109_5822;
      prog[4]  = 32'h0109_6024;
      prog[5]  = 32'h0109_6825;
      prog[6]  = 32'h0128_702A;
      prog[7]  = 32'hAC0A_0000;
      prog[8]  = 32'h8C0F_0000;
      prog[9]  = 32'h11EA_0001;
      prog[10] = 32'h2008_00FF;
      prog[11] = 32'h0800_0000;
      m_reset();
      rst = 1'b1;

      test_reset();
      test_program();
      test_loop();
      test_mid_reset();
      test_random_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
